// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: burst controller for a 512 x 32 byte-writable single-port RAM.
// Write bursts stream wr_data beats straight onto the RAM port. Read bursts
// issue addresses into a two-entry skid buffer, which gives one word per
// cycle with rd_ready high and loses nothing under backpressure.
// Optional macro RAM_BURST_CTRL_WRAP_CHECK_EN adds an err port. With it, a
// command whose burst would cross address 511 is accepted and dropped. Without
// it, addresses wrap from 511 to 0.
module ram_burst_ctrl (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [8:0]  cmd_addr,
   input  logic [8:0]  cmd_len,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [31:0] wr_data,
   input  logic [3:0]  wr_be,
   output logic        rd_valid,
   input  logic        rd_ready,
   output logic [31:0] rd_data,
   output logic        rd_last,
   output logic        done,
   output logic        busy,
   output logic        ram_en,
   output logic [3:0]  ram_we,
   output logic [8:0]  ram_a,
   output logic [31:0] ram_di,
`ifdef RAM_BURST_CTRL_WRAP_CHECK_EN
   output logic        err,
`endif
   input  logic [31:0] ram_do
);

   typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

   state_t      state_q, state_d;
   logic [8:0]  addr_q, addr_d;
   logic [8:0]  cnt_q, cnt_d;
   logic        cmd_ready_q, cmd_ready_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        infl_q, infl_d;
   logic        infl_last_q, infl_last_d;
   logic [1:0]  occ_q, occ_d;
   logic [31:0] buf0_q, buf0_d, buf1_q, buf1_d;
   logic        last0_q, last0_d, last1_q, last1_d;
`ifdef RAM_BURST_CTRL_WRAP_CHECK_EN
   logic        err_q, err_d;
   logic [9:0]  end_addr;
`endif

   logic        cmd_fire, wr_fire, rd_valid_w, pop, issue;
   logic [2:0]  room;

   // Handshakes and read-issue decision. A word in flight counts as buffered,
   // so buffer slots plus the in-flight word can never exceed two.
   always_comb begin
      cmd_fire   = cmd_valid && cmd_ready_q;
      wr_fire    = (state_q == WRITE) && wr_valid;
      rd_valid_w = (occ_q != 2'd0) || infl_q;
      pop        = rd_valid_w && rd_ready;
      room       = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
      issue      = (state_q == READ) && (room < 3'd2);
   end

   // Next-state logic for the burst FSM, counters and skid buffer.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      done_d      = 1'b0;
      infl_d      = issue;
      infl_last_d = issue && (cnt_q == 9'd0);
      occ_d       = occ_q;
      buf0_d      = buf0_q;
      buf1_d      = buf1_q;
      last0_d     = last0_q;
      last1_d     = last1_q;
`ifdef RAM_BURST_CTRL_WRAP_CHECK_EN
      err_d       = 1'b0;
      end_addr    = {1'b0, cmd_addr} + {1'b0, cmd_len};
`endif
      case (state_q)
         IDLE: begin
            if (cmd_fire) begin
`ifdef RAM_BURST_CTRL_WRAP_CHECK_EN
               if (end_addr > 10'd511) begin
                  err_d = 1'b1;
               end else begin
                  state_d = cmd_write ? WRITE : READ;
                  addr_d  = cmd_addr;
                  cnt_d   = cmd_len;
               end
`else
               state_d = cmd_write ? WRITE : READ;
               addr_d  = cmd_addr;
               cnt_d   = cmd_len;
`endif
            end
         end
         WRITE: begin
            if (wr_fire) begin
               addr_d = addr_q + 9'd1;
               if (cnt_q == 9'd0) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q - 9'd1;
               end
            end
         end
         READ: begin
            if (issue) begin
               addr_d = addr_q + 9'd1;
               if (cnt_q == 9'd0) state_d = DRAIN;
               else               cnt_d   = cnt_q - 9'd1;
            end
         end
         default: begin
            if ((occ_q == 2'd0) && !infl_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
      endcase

      // The word returning from RAM is either handed straight out (buffer
      // empty and consumer ready) or appended behind any older entries.
      case (occ_q)
         2'd0: begin
            if (infl_q && !pop) begin
               buf0_d  = ram_do;
               last0_d = infl_last_q;
               occ_d   = 2'd1;
            end
         end
         2'd1: begin
            if (infl_q && pop) begin
               buf0_d  = ram_do;
               last0_d = infl_last_q;
            end else if (pop) begin
               occ_d = 2'd0;
            end else if (infl_q) begin
               buf1_d  = ram_do;
               last1_d = infl_last_q;
               occ_d   = 2'd2;
            end
         end
         default: begin
            if (pop) begin
               buf0_d  = buf1_q;
               last0_d = last1_q;
               if (infl_q) begin
                  buf1_d  = ram_do;
                  last1_d = infl_last_q;
               end else begin
                  occ_d = 2'd1;
               end
            end
         end
      endcase

      cmd_ready_d = (state_d == IDLE);
      busy_d      = (state_d != IDLE);
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q     <= IDLE;
         addr_q      <= 9'd0;
         cnt_q       <= 9'd0;
         cmd_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         infl_q      <= 1'b0;
         infl_last_q <= 1'b0;
         occ_q       <= 2'd0;
         buf0_q      <= 32'd0;
         buf1_q      <= 32'd0;
         last0_q     <= 1'b0;
         last1_q     <= 1'b0;
`ifdef RAM_BURST_CTRL_WRAP_CHECK_EN
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         infl_q      <= infl_d;
         infl_last_q <= infl_last_d;
         occ_q       <= occ_d;
         buf0_q      <= buf0_d;
         buf1_q      <= buf1_d;
         last0_q     <= last0_d;
         last1_q     <= last1_d;
`ifdef RAM_BURST_CTRL_WRAP_CHECK_EN
         err_q       <= err_d;
`endif
      end
   end

   // Output drive: write beats go to the RAM port in the cycle they are accepted.
   always_comb begin
      cmd_ready = cmd_ready_q;
      busy      = busy_q;
      done      = done_q;
      wr_ready  = (state_q == WRITE);
      rd_valid  = rd_valid_w;
      rd_data   = (occ_q != 2'd0) ? buf0_q  : (infl_q ? ram_do : 32'd0);
      rd_last   = (occ_q != 2'd0) ? last0_q : (infl_q && infl_last_q);
      ram_en    = wr_fire || issue;
      ram_we    = wr_fire ? wr_be : 4'd0;
      ram_a     = addr_q;
      ram_di    = wr_fire ? wr_data : 32'd0;
`ifdef RAM_BURST_CTRL_WRAP_CHECK_EN
      err       = err_q;
`endif
   end

endmodule

// File: doc/ram_burst_ctrl.md
RAM_BURST_CTRL -- requirements
Module: ram_burst_ctrl

Interface
REQ-001 Parameters: none; geometry is fixed at 512 words x 32 bits, 9-bit word address, 4 byte lanes.
REQ-002 CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 RST_N  in  1  reset, synchronous, active-low.
REQ-004 cmd_valid / cmd_ready  in / out  1 / 1  burst command handshake; transfer when both high.
REQ-005 cmd_write  in  1  1 = write burst, 0 = read burst.
REQ-006 cmd_addr  in  9  first word address.
REQ-007 cmd_len  in  9  burst length minus one (0..511 -> 1..512 words).
REQ-008 wr_valid / wr_ready  in / out  1 / 1  write-data beat handshake.
REQ-009 wr_data / wr_be  in  32 / 4  write word and byte enables (bit n -> bits 8n+7:8n).
REQ-010 rd_valid / rd_ready  out / in  1 / 1  read-data beat handshake.
REQ-011 rd_data / rd_last  out  32 / 1  read word; rd_last flags final beat of burst.
REQ-012 done  out  1  one-cycle pulse at burst completion.
REQ-013 busy  out  1  high whenever state is not IDLE.
REQ-014 ram_en / ram_we / ram_a / ram_di  out  1 / 4 / 9 / 32  drive RAM port enable, byte writes, address, write data.
REQ-015 ram_do  in  32  RAM read data, valid the cycle after ram_en=1 with ram_we=0; zero otherwise.

Function
REQ-016 States: IDLE, WRITE, READ, DRAIN; cmd_ready=1 only in IDLE.
REQ-017 IDLE + command accepted -> WRITE if cmd_write=1, else READ; address counter <= cmd_addr, beat counter <= cmd_len.
REQ-018 WRITE: wr_ready=1; each accepted beat drives ram_en=1, ram_we=wr_be, ram_a=counter, ram_di=wr_data in the same cycle (combinational); no beat -> ram_en=0, ram_we=0.
REQ-019 WRITE: wr_be=0 beats still consume a beat and advance the address.
REQ-020 WRITE: final beat accepted -> IDLE; done=1 the following cycle.
REQ-021 READ: ram_we=0 always; issue read (ram_en=1) when occupancy + in-flight - pop < 2, where skid buffer depth is 2 and in-flight <= 1.
REQ-022 ram_do captured into skid buffer exactly one cycle after each issue; never sampled otherwise.
REQ-023 rd_valid=1 while skid buffer non-empty; rd_data/rd_last from oldest entry; pop on rd_valid & rd_ready.
REQ-024 Read latency: command accepted cycle 0, ram_en cycle 1, rd_valid cycle 2; sustained 1 word/cycle with rd_ready held high.
REQ-025 READ: last issue -> DRAIN; DRAIN -> IDLE when buffer empty and nothing in flight; done=1 the following cycle.
REQ-026 Address increments by 1 per beat, wrapping 511 -> 0 (subject to REQ-032).
REQ-027 rd_ready low stalls issue; no word lost or duplicated.
REQ-028 wr_valid and rd_ready outside their states are ignored; cmd_valid while busy is held off, not dropped.

Reset
REQ-029 RST_N low at an edge: state <= IDLE, counters <= 0, skid buffer and in-flight flag cleared.
REQ-030 Reset values: cmd_ready=0 during reset, 1 the cycle after release; wr_ready, rd_valid, rd_last, done, busy, ram_en = 0; ram_we=0; ram_a, ram_di, rd_data = 0.
REQ-031 Reset mid-burst abandons the burst: no done pulse, partially written words stay in RAM.

Configuration
REQ-032 Macro RAM_BURST_CTRL_WRAP_CHECK_EN defined: a command with cmd_addr + cmd_len > 511 is accepted but not executed, adds output err (1 bit, reset 0) pulsed one cycle after accept, with no RAM access and no done pulse; undefined: no err port, and wrap per REQ-026.

Verification
REQ-033 Write addr=0x010 len=3, data 0xA0..0xA3, be=0xF -> ram_a 0x010..0x013 with ram_we=0xF, done 1 cycle after 4th beat.
REQ-034 Read addr=0x010 len=3, rd_ready=1 -> rd_valid cycles 2..5, data 0xA0..0xA3, rd_last with 0xA3.
REQ-035 Same read, rd_ready toggled 1,0,0,1,0,1... -> same 4 words in order, ram_en never asserted with buffer full.
REQ-036 Write addr=0x1FE len=3, be=0x1 -> ram_a 0x1FE,0x1FF,0x000,0x001 (macro off); macro on -> err pulse, ram_en stays 0.
REQ-037 RST_N low during beat 2 of an 8-beat read -> next cycle rd_valid=0, busy=0, no done; new command accepted after release.
